// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array operand feeder.
package systolic_pkg;

  localparam int OP_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_t;

  typedef logic signed [OP_WIDTH-1:0] op_t;

  // Cycles needed to push every operand through the most-skewed lane.
  function automatic int stream_len(input int size, input int skew);
    return size + skew * (size - 1);
  endfunction

endpackage

// File: rtl/systolic_operand_bank.sv
// SIZE x SIZE operand register bank: one write port, one combinational read per lane.
module operand_bank #(
  parameter int SIZE       = 3,
  parameter int DATA_WIDTH = 8,
  parameter int IW         = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [IW-1:0]                wr_row,
  input  logic [IW-1:0]                wr_col,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic [IW-1:0]                rd_row  [SIZE],
  input  logic [IW-1:0]                rd_col  [SIZE],
  output logic signed [DATA_WIDTH-1:0] rd_data [SIZE]
);

  localparam logic [IW:0] SIZE_LIM = (IW+1)'(SIZE);

  logic signed [DATA_WIDTH-1:0] mem [SIZE][SIZE];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else if (wr_en) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  // Out-of-range addresses read as zero so no lane ever indexes past the array.
  always_comb begin
    for (int l = 0; l < SIZE; l++) begin
      rd_data[l] = '0;
      if (({1'b0, rd_row[l]} < SIZE_LIM) && ({1'b0, rd_col[l]} < SIZE_LIM)) begin
        rd_data[l] = mem[rd_row[l]][rd_col[l]];
      end
    end
  end

endmodule

// File: rtl/systolic_operand_feeder.sv
// Loads A/B operand banks and streams them, diagonally skewed, into the systolic array.
//   state  | meaning
//   IDLE   | banks writable, waiting for start
//   CLEAR  | one-cycle accumulator clear, operands zero
//   STREAM | step t drives A row lanes / B column lanes
//   DRAIN  | zero operands while the last products settle
//   DONE   | one-cycle done pulse, still busy
module systolic_operand_feeder
  import systolic_pkg::*;
#(
  parameter int SIZE         = 3,
  parameter int DATA_WIDTH   = OP_WIDTH,
  parameter int SKEW         = 1,
  parameter int DRAIN_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         wr_sel,
  input  logic [$clog2(SIZE)-1:0]      wr_row,
  input  logic [$clog2(SIZE)-1:0]      wr_col,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  output logic                         wr_err,
  input  logic                         start,
  output logic                         busy,
  output logic                         ready,
  output logic                         clear_out,
  output logic signed [DATA_WIDTH-1:0] A_out [SIZE],
  output logic signed [DATA_WIDTH-1:0] B_out [SIZE],
  output logic                         done
);

  localparam int IW = $clog2(SIZE);
  localparam int T  = stream_len(SIZE, SKEW);
  localparam int CW = $clog2(T + DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] STREAM_LAST = CW'(T - 1);
  localparam logic [CW-1:0] DRAIN_LAST  = CW'(T + DRAIN_CYCLES - 1);
  localparam logic [IW:0]   SIZE_LIM    = (IW+1)'(SIZE);

  feeder_state_t state, nxt_state;
  logic [CW-1:0] step, nxt_step;
  logic          wr_ok;
  int            lane_k [SIZE];
  logic [SIZE-1:0] lane_ok;
  logic [IW-1:0] a_rd_row [SIZE];
  logic [IW-1:0] a_rd_col [SIZE];
  logic [IW-1:0] b_rd_row [SIZE];
  logic [IW-1:0] b_rd_col [SIZE];
  logic signed [DATA_WIDTH-1:0] a_rd [SIZE];
  logic signed [DATA_WIDTH-1:0] b_rd [SIZE];

  assign wr_ok = wr_en && (state == IDLE) &&
                 ({1'b0, wr_row} < SIZE_LIM) && ({1'b0, wr_col} < SIZE_LIM);

  always_comb begin
    nxt_state = state;
    nxt_step  = step;
    case (state)
      IDLE:   if (start) nxt_state = CLEAR;
      CLEAR: begin
        nxt_state = STREAM;
        nxt_step  = '0;
      end
      STREAM: begin
        if (step == STREAM_LAST) begin
          nxt_state = (DRAIN_CYCLES > 0) ? DRAIN : DONE;
        end
        nxt_step = step + CW'(1);
      end
      DRAIN: begin
        if (step == DRAIN_LAST) nxt_state = DONE;
        nxt_step = step + CW'(1);
      end
      DONE: begin
        nxt_state = IDLE;
        nxt_step  = '0;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Outputs are registered, so bank reads are addressed by the step about to be shown.
  always_comb begin
    for (int l = 0; l < SIZE; l++) begin
      lane_k[l]   = int'(nxt_step) - SKEW * l;
      lane_ok[l]  = (nxt_state == STREAM) && (lane_k[l] >= 0) && (lane_k[l] < SIZE);
      a_rd_row[l] = IW'(l);
      a_rd_col[l] = IW'(lane_k[l]);
      b_rd_row[l] = IW'(lane_k[l]);
      b_rd_col[l] = IW'(l);
    end
  end

  operand_bank #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .IW(IW)) u_bank_a (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_ok && !wr_sel),
    .wr_row (wr_row),
    .wr_col (wr_col),
    .wr_data(wr_data),
    .rd_row (a_rd_row),
    .rd_col (a_rd_col),
    .rd_data(a_rd)
  );

  operand_bank #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .IW(IW)) u_bank_b (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_ok && wr_sel),
    .wr_row (wr_row),
    .wr_col (wr_col),
    .wr_data(wr_data),
    .rd_row (b_rd_row),
    .rd_col (b_rd_col),
    .rd_data(b_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      step      <= '0;
      busy      <= 1'b0;
      ready     <= 1'b1;
      clear_out <= 1'b0;
      done      <= 1'b0;
      wr_err    <= 1'b0;
      for (int l = 0; l < SIZE; l++) begin
        A_out[l] <= '0;
        B_out[l] <= '0;
      end
    end else begin
      state     <= nxt_state;
      step      <= nxt_step;
      busy      <= (nxt_state != IDLE);
      ready     <= (nxt_state == IDLE);
      clear_out <= (nxt_state == CLEAR);
      done      <= (nxt_state == DONE);
      wr_err    <= wr_en && !wr_ok;
      for (int l = 0; l < SIZE; l++) begin
        A_out[l] <= lane_ok[l] ? a_rd[l] : '0;
        B_out[l] <= lane_ok[l] ? b_rd[l] : '0;
      end
    end
  end

endmodule

// File: doc/systolic_operand_feeder.md
Name: systolic_operand_feeder

Overview:
Upstream stage of the systolic matrix-multiply array. It holds one SIZE x SIZE A matrix and one SIZE x SIZE B matrix in internal register banks, loaded one element per write. On start it pulses the array's clear, then streams A rows and B columns into the array's row/column inputs with a per-lane diagonal skew, flushes with zeros, and signals done when the accumulators hold the final product.

Parameters:
SIZE, 3, matrix dimension and number of row/column lanes
DATA_WIDTH, 8, signed operand width
SKEW, 1, lane delay per index: 1 = row i / column j delayed i / j cycles; 0 = all lanes aligned
DRAIN_CYCLES, 1, zero cycles after the last operand before done

Ports:
clk  in  1  clock
rst  in  1  reset (asynchronous, active-low)
wr_en  in  1  write one matrix element
wr_sel  in  1  0 = A bank, 1 = B bank
wr_row  in  $clog2(SIZE)  element row index
wr_col  in  $clog2(SIZE)  element column index
wr_data  in  DATA_WIDTH  signed element value
wr_err  out  1  one-cycle pulse: write rejected (busy or index >= SIZE)
start  in  1  begin a multiply
busy  out  1  high from CLEAR through DONE
ready  out  1  equals !busy
clear_out  out  1  one-cycle accumulator clear to the array
A_out  out  SIZE x DATA_WIDTH signed  row lane i operand
B_out  out  SIZE x DATA_WIDTH signed  column lane j operand
done  out  1  one-cycle pulse: result valid in the array

Behaviour:
- Reset values: all outputs 0, except ready = 1. FSM returns to IDLE. Banks reset to 0.
- Reset mid-operation aborts immediately. Outputs take their reset values. Bank contents are also reset.
- Writes are accepted only in IDLE with indices < SIZE. An accepted write updates the bank at that clk edge.
- Any other write is dropped. wr_err pulses in the following cycle.
- wr_en and start in the same IDLE cycle: the write commits, and streaming uses the new value.
- start is ignored while busy.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE. All outputs are registered.
- IDLE -> CLEAR: on start sampled at edge N.
- CLEAR: cycle N+1. clear_out = 1; A_out and B_out are all 0. Always exactly one cycle.
- STREAM: T = SIZE + SKEW*(SIZE-1) cycles, with t = 0..T-1 counted by an internal step counter.
- STREAM outputs: A_out[i] = A[i][t - SKEW*i] and B_out[j] = B[t - SKEW*j][j] when the index is in 0..SIZE-1, else 0.
- DRAIN: DRAIN_CYCLES cycles with all operands 0. DRAIN_CYCLES = 0 skips the state.
- DONE: one cycle. done = 1 and busy is still 1. Next cycle returns to IDLE with ready = 1.
- Total latency: start edge to done cycle = 1 + T + DRAIN_CYCLES + 1 cycles.
- Values are passed bit-exact, signed. There is no arithmetic on operands.
- The step counter width is $clog2(T+DRAIN_CYCLES+1). It never wraps within an operation.
- Back-to-back: start asserted in the DONE cycle is ignored. start is accepted from the first IDLE cycle.

Decomposition:
- Shared package systolic_pkg holds:
  - state enum feeder_state_t {IDLE, CLEAR, STREAM, DRAIN, DONE}
  - operand typedef op_t, logic signed [DATA_WIDTH-1:0]
  - function stream_len(SIZE, SKEW)
- One natural sub-module, operand_bank: a SIZE x SIZE register bank with a write port and a combinational read of one element per lane (index computed by the parent). It is instantiated twice, for A and B.

Test Plan:
- SIZE=3, SKEW=1, A = [[1,2,3],[4,5,6],[7,8,9]], B = A, start at edge 0.
  - Expect clear_out in cycle 1.
  - A_out per cycle 2..6: {1,0,0}, {2,4,0}, {3,5,7}, {0,6,8}, {0,0,9}.
  - B_out per cycle 2..6: {1,0,0}, {4,2,0}, {7,5,3}, {0,8,6}, {0,0,9}.
  - Cycle 7 all zeros; done in cycle 8; ready in cycle 9.
- SKEW=0, same matrices -> A_out cycles 2..4 = {1,4,7}, {2,5,8}, {3,6,9}; B_out = {1,2,3}, {4,5,6}, {7,8,9}; done in cycle 6.
- Write wr_data = -128 to A[2][1] -> A_out[2] = 8'h80 in stream step t=3 (SKEW=1).
- wr_en during STREAM, and a separate write with wr_row = 3 -> wr_err pulses; bank unchanged; next run's outputs match the original data.
- start while busy -> no restart, done pulses exactly once. wr_en and start in the same cycle -> the new value is streamed.
- rst low in STREAM step 2 -> outputs 0 and ready = 1 asynchronously; a subsequent start streams all zeros (banks cleared).
